// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - coin sensor conditioner, width classifier and credit pulse generator
module coin_acceptor #(
  parameter int DEB        = 4,
  parameter int CNT_W      = 8,
  parameter int HALF_MIN   = 20,
  parameter int HALF_MAX   = 40,
  parameter int ONE_MIN    = 60,
  parameter int ONE_MAX    = 100,
  parameter int REJ_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       coin_sense,
  input  logic       inhibit,
  output logic       one_dollar,
  output logic       half_dollar,
  output logic       reject_gate,
  output logic [7:0] accepted_cnt
);

  localparam int LW = $clog2(DEB + 1);
  localparam int RW = (REJ_CYCLES > 1) ? $clog2(REJ_CYCLES) : 1;

  localparam logic [CNT_W-1:0] W_DEB      = CNT_W'(DEB);
  localparam logic [CNT_W-1:0] W_SAT      = '1;
  localparam logic [CNT_W-1:0] W_HALF_MIN = CNT_W'(HALF_MIN);
  localparam logic [CNT_W-1:0] W_HALF_MAX = CNT_W'(HALF_MAX);
  localparam logic [CNT_W-1:0] W_ONE_MIN  = CNT_W'(ONE_MIN);
  localparam logic [CNT_W-1:0] W_ONE_MAX  = CNT_W'(ONE_MAX);
  localparam logic [LW-1:0]    LOW_DEB    = LW'(DEB);
  localparam logic [RW-1:0]    REJ_LAST   = RW'(REJ_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, ARM, MEASURE, TRAIL, CLASSIFY, REJECT
  } state_t;

  state_t           state;
  logic             s_meta;
  logic             s;
  logic [CNT_W-1:0] w;
  logic [LW-1:0]    lowcnt;
  logic [RW-1:0]    rej_cnt;

  logic [CNT_W-1:0] w_inc;
  logic [LW-1:0]    lowcnt_inc;

  // Width counter holds at all-ones so oversized coins stay recognisable.
  assign w_inc      = (w == W_SAT) ? w : w + 1'b1;
  assign lowcnt_inc = lowcnt + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_meta       <= 1'b0;
      s            <= 1'b0;
      state        <= IDLE;
      w            <= '0;
      lowcnt       <= '0;
      rej_cnt      <= '0;
      one_dollar   <= 1'b0;
      half_dollar  <= 1'b0;
      reject_gate  <= 1'b0;
      accepted_cnt <= '0;
    end else begin
      s_meta      <= coin_sense;
      s           <= s_meta;
      one_dollar  <= 1'b0;
      half_dollar <= 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state <= ARM;
            w     <= CNT_W'(1);
          end
        end
        ARM: begin
          if (s) begin
            w <= w_inc;
            if (w_inc == W_DEB) state <= MEASURE;
          end else begin
            state <= IDLE;
          end
        end
        MEASURE: begin
          if (s) begin
            w <= w_inc;
          end else begin
            state  <= TRAIL;
            lowcnt <= LW'(1);
          end
        end
        TRAIL: begin
          // A bounce resumes measuring; the low cycles are not added to w.
          if (s) begin
            w     <= w_inc;
            state <= MEASURE;
          end else begin
            lowcnt <= lowcnt_inc;
            if (lowcnt_inc == LOW_DEB) state <= CLASSIFY;
          end
        end
        CLASSIFY: begin
          if (inhibit || (w == W_SAT)) begin
            state       <= REJECT;
            reject_gate <= 1'b1;
            rej_cnt     <= '0;
          end else if ((w >= W_HALF_MIN) && (w <= W_HALF_MAX)) begin
            half_dollar  <= 1'b1;
            accepted_cnt <= accepted_cnt + 1'b1;
            state        <= IDLE;
          end else if ((w >= W_ONE_MIN) && (w <= W_ONE_MAX)) begin
            one_dollar   <= 1'b1;
            accepted_cnt <= accepted_cnt + 1'b1;
            state        <= IDLE;
          end else begin
            state       <= REJECT;
            reject_gate <= 1'b1;
            rej_cnt     <= '0;
          end
        end
        REJECT: begin
          if (rej_cnt == REJ_LAST) begin
            reject_gate <= 1'b0;
            state       <= IDLE;
          end else begin
            rej_cnt <= rej_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - directed self-checking bench for coin_acceptor
module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       coin_sense;
  logic       inhibit;
  logic       one_dollar;
  logic       half_dollar;
  logic       reject_gate;
  logic [7:0] accepted_cnt;

  int n_cmp = 0;
  int n_err = 0;

  int n_half = 0;
  int n_one  = 0;
  int n_rej  = 0;
  int n_ovl  = 0;

  int b_half, b_one, b_rej;

  coin_acceptor dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .coin_sense   (coin_sense),
    .inhibit      (inhibit),
    .one_dollar   (one_dollar),
    .half_dollar  (half_dollar),
    .reject_gate  (reject_gate),
    .accepted_cnt (accepted_cnt)
  );

  always #5 clk = ~clk;

  // High-cycle counters for each output, sampled away from the active edge.
  always @(negedge clk) begin
    if (half_dollar) n_half++;
    if (one_dollar)  n_one++;
    if (reject_gate) n_rej++;
    if ((32'(half_dollar) + 32'(one_dollar) + 32'(reject_gate)) > 1) n_ovl++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_half = n_half;
    b_one  = n_one;
    b_rej  = n_rej;
  endtask

  task automatic coin(input int n);
    coin_sense = 1'b1;
    tick(n);
    coin_sense = 1'b0;
  endtask

  task automatic deltas(input string tag, input int dh, input int d1, input int dr);
    chk({tag, "_half"}, n_half - b_half, dh);
    chk({tag, "_one"},  n_one - b_one,   d1);
    chk({tag, "_rej"},  n_rej - b_rej,   dr);
  endtask

  initial begin
    reset_n    = 1'b0;
    coin_sense = 1'b1;
    inhibit    = 1'b0;
    tick(10);
    chk("rst_one",  32'(one_dollar),   0);
    chk("rst_half", 32'(half_dollar),  0);
    chk("rst_rej",  32'(reject_gate),  0);
    chk("rst_cnt",  32'(accepted_cnt), 0);

    snap();
    reset_n    = 1'b1;
    coin_sense = 1'b0;
    tick(30);
    deltas("post_rst", 0, 0, 0);

    // 30-cycle coin: half-dollar pulse exactly at E(2+DEB) after first low sample.
    snap();
    coin(30);
    tick(6);
    chk("half_early", 32'(half_dollar), 0);
    tick(1);
    chk("half_on",    32'(half_dollar), 1);
    chk("half_cnt",   32'(accepted_cnt), 1);
    tick(1);
    chk("half_off",   32'(half_dollar), 0);
    tick(30);
    deltas("half", 1, 0, 0);

    // 40 high, 2 low bounce, 40 high: one measurement of 80.
    snap();
    coin(40);
    tick(2);
    coin(40);
    tick(40);
    deltas("bounce", 0, 1, 0);
    chk("bounce_cnt", 32'(accepted_cnt), 2);

    snap();
    coin(2);
    tick(30);
    deltas("glitch", 0, 0, 0);

    snap();
    coin(50);
    tick(40);
    deltas("gap50", 0, 0, 16);

    snap();
    coin(300);
    tick(40);
    deltas("sat", 0, 0, 16);
    chk("sat_cnt", 32'(accepted_cnt), 2);

    snap();
    inhibit = 1'b1;
    coin(80);
    tick(40);
    inhibit = 1'b0;
    deltas("inhibit", 0, 0, 16);
    chk("inhibit_cnt", 32'(accepted_cnt), 2);

    snap();
    coin(80);
    tick(20);
    coin(80);
    tick(40);
    deltas("two", 0, 2, 0);
    chk("two_cnt", 32'(accepted_cnt), 4);

    // Reset in MEASURE clears the count immediately and loses the coin.
    snap();
    coin_sense = 1'b1;
    tick(30);
    reset_n = 1'b0;
    #1;
    chk("midrst_cnt", 32'(accepted_cnt), 0);
    chk("midrst_rej", 32'(reject_gate),  0);
    coin_sense = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(40);
    deltas("midrst", 0, 0, 0);

    snap();
    for (int i = 0; i < 255; i++) begin
      coin(30);
      tick(8);
    end
    chk("wrap_255", 32'(accepted_cnt), 255);
    coin(30);
    tick(10);
    chk("wrap_0", 32'(accepted_cnt), 0);
    deltas("wrap", 256, 0, 0);

    chk("overlap", n_ovl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
Front-end for the `sell` vending FSM. It conditions the raw optical coin sensor and measures how long each coin blocks the sensor. From that width it classifies the coin as half-dollar, one-dollar or invalid. It then issues single-cycle `half_dollar` / `one_dollar` credit pulses that drive `sell`'s coin inputs directly, and opens the return gate for rejected coins.

Parameters:
DEB, 4, consecutive synchronized samples needed to accept a level change (debounce)
CNT_W, 8, width-counter bits; counter saturates at 2^CNT_W-1
HALF_MIN, 20, min width (cycles) for half-dollar
HALF_MAX, 40, max width for half-dollar
ONE_MIN, 60, min width for one-dollar
ONE_MAX, 100, max width for one-dollar; HALF_MAX < ONE_MIN and ONE_MAX < 2^CNT_W-1 are required
REJ_CYCLES, 16, cycles reject_gate stays open

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
coin_sense  in  1  raw sensor, asynchronous, high while a coin blocks the beam
inhibit  in  1  vend busy; coins classified while high are rejected
one_dollar  out  1  one-cycle credit pulse to sell
half_dollar  out  1  one-cycle credit pulse to sell
reject_gate  out  1  return-chute solenoid
accepted_cnt  out  8  count of accepted coins, wraps 255->0

Behaviour:
- Reset (reset_n=0, async): both sync flops=0, state IDLE, all counters 0. All outputs 0 immediately. Reset mid-operation discards the coin in progress; no credit or reject is issued after release.
- Synchronizer: two flops. s = second-flop output. All FSM decisions use s only.
- Width counter `w` counts cycles with s=1 from ARM entry, saturating. All counters and outputs are registered.
- IDLE: s=1 -> ARM, w=1.
- ARM: s=1 -> w++; when w reaches DEB -> MEASURE. If s=0 before that -> IDLE (glitch; no output, no count).
- MEASURE: s=1 -> w++. s=0 -> TRAIL, lowcnt=1.
- TRAIL: s=0 -> lowcnt++; when lowcnt reaches DEB -> CLASSIFY. If s=1 first (bounce) -> MEASURE; w resumes incrementing and low cycles are not added to w.
- CLASSIFY (exactly one cycle), evaluated in this priority order:
  - inhibit=1, or w saturated -> REJECT.
  - HALF_MIN<=w<=HALF_MAX -> half_dollar=1 next cycle, accepted_cnt++, -> IDLE.
  - ONE_MIN<=w<=ONE_MAX -> one_dollar=1 next cycle, accepted_cnt++, -> IDLE.
  - otherwise -> REJECT.
- REJECT: reject_gate=1 for exactly REJ_CYCLES cycles, then IDLE. coin_sense is ignored in REJECT; a coin still blocking the beam on exit is measured from ARM as a fresh coin.
- Latency: raw low sampled at edge E0 -> s low after E1 -> CLASSIFY entered at E(1+DEB) -> credit pulse high from E(2+DEB) to E(3+DEB). reject_gate rises at E(2+DEB).
- Mutual exclusion: one_dollar, half_dollar and reject_gate are never high together; at most one credit pulse per coin.
- inhibit is sampled only in CLASSIFY.

Test Plan:
- Hold reset_n=0 with coin_sense=1 for 10 cycles -> all outputs 0, accepted_cnt=0. Release, drop coin_sense -> no output (coin arrived during reset, raw low before ARM completes is fine; any sub-DEB high is a glitch).
- coin_sense high 30 cycles, then low -> half_dollar high exactly 1 cycle, DEB+2=6 edges after first low sample; accepted_cnt=1; reject_gate stays 0.
- coin_sense high 40 cycles, low 2 cycles (bounce), high 40 cycles, then low -> single one_dollar pulse (w=80); accepted_cnt increments by 1.
- Width checks:
  - coin_sense high 2 cycles -> nothing.
  - High 50 cycles -> reject_gate high 16 cycles, no credit.
  - High 300 cycles (saturates) -> reject.
- inhibit=1 during an 80-cycle coin -> reject_gate high 16 cycles, no credit, accepted_cnt unchanged.
- Two 80-cycle coins separated by 20 low cycles -> two one_dollar pulses, accepted_cnt +2.
- Assert reset_n=0 mid-MEASURE -> outputs 0 immediately and no pulse after release.
- 256 accepted coins -> accepted_cnt wraps to 0.
